// File: rtl/hpdl1414_scanner.sv
// hpdl1414_scanner: continuously copies the 16-entry character memory into four
// chained HPDL-1414 displays and generates the caret blink strobe.
module hpdl1414_scanner #(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_DIV    = 2500000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  output logic       o_read_enable,
  output logic [3:0] o_read_address,
  input  logic [7:0] i_read_data,
  output logic       o_caret_strobe,
  output logic [6:0] o_disp_data,
  output logic [1:0] o_disp_addr,
  output logic [3:0] o_disp_wr_n
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] LATCH  = 3'd2;
  localparam logic [2:0] SETUP  = 3'd3;
  localparam logic [2:0] STROBE = 3'd4;
  localparam logic [2:0] HOLD   = 3'd5;
  localparam logic [2:0] NEXT   = 3'd6;

  localparam int MAX_SP    = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_PHASE = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
  localparam int PW = $clog2(MAX_PHASE + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] SETUP_LAST   = PW'(SETUP_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LAST    = PW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [2:0]    state;
  logic [3:0]    index;
  logic [PW-1:0] phase;
  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  logic          frame_pending;
  logic          frame_start;

  function automatic logic [6:0] map_char(input logic [7:0] b);
    logic [7:0] upper;
    upper = b - 8'h20;
    if (b >= 8'h20 && b <= 8'h5F)      map_char = b[6:0];
    else if (b >= 8'h61 && b <= 8'h7A) map_char = upper[6:0];
    else                               map_char = 7'h20;
  endfunction

  assign frame_start = (state == IDLE) && frame_pending && i_enable;

  // A wrap that coincides with a frame start stays pending so the tick is not lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      refresh_cnt   <= '0;
      frame_pending <= 1'b1;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt   <= '0;
      frame_pending <= 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
      if (frame_start) frame_pending <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt      <= '0;
      o_caret_strobe <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt      <= '0;
      o_caret_strobe <= ~o_caret_strobe;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      index       <= '0;
      phase       <= '0;
      o_disp_data <= '0;
      o_disp_addr <= '0;
    end else begin
      case (state)
        IDLE:  if (frame_start) state <= READ;
        READ:  state <= LATCH;
        LATCH: begin
          // HPDL digit 0 is the rightmost, so index 0 lands on digit 3.
          o_disp_data <= map_char(i_read_data);
          o_disp_addr <= ~index[1:0];
          phase       <= '0;
          state       <= SETUP;
        end
        SETUP: begin
          if (phase == SETUP_LAST) begin
            phase <= '0;
            state <= STROBE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        STROBE: begin
          if (phase == PULSE_LAST) begin
            phase <= '0;
            state <= HOLD;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        HOLD: begin
          if (phase == HOLD_LAST) begin
            phase <= '0;
            state <= NEXT;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        NEXT: begin
          if (index == 4'd15 || !i_enable) begin
            index <= '0;
            state <= IDLE;
          end else begin
            index <= index + 4'd1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobe decoded from state so an async reset releases it immediately.
  assign o_disp_wr_n    = (state == STROBE) ? ~(4'b0001 << index[3:2]) : 4'hF;
  assign o_read_enable  = (state == READ);
  assign o_read_address = index;

endmodule

// File: tb/tb_hpdl1414_scanner.sv
// tb_hpdl1414_scanner: scoreboard bench for the HPDL-1414 scanner, with a
// second instance whose refresh period is shorter than one frame.
module tb_hpdl1414_scanner;

  localparam int SETUP = 1;
  localparam int PULSE = 2;
  localparam int HOLD = 1;
  localparam int RDIV = 200;
  localparam int RDIV_FAST = 20;
  localparam int BDIV = 8;
  localparam int CHAR_CLKS = 3 + SETUP + PULSE + HOLD;
  localparam int FAST_FRAME = 16 * CHAR_CLKS + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst_fast_n = 1'b1;
  logic en = 1'b1;
  logic en_fast = 1'b1;

  logic       readEn, readEnF;
  logic [3:0] readAddr, readAddrF;
  logic [7:0] rdata, rdataF;
  logic       caret, caretF;
  logic [6:0] dispData, dispDataF;
  logic [1:0] dispAddr, dispAddrF;
  logic [3:0] wrN, wrNF;

  logic [7:0] mem[16];
  logic [7:0] memF[16];

  int vectors = 0;
  int miscompares = 0;
  int cyc, cycF;

  logic [10:0] sbQueue[$];
  logic [10:0] sbQueueF[$];
  logic [3:0]  expK = 4'd0;
  logic [3:0]  expKF = 4'd0;
  logic        restart = 1'b1;
  logic [3:0]  prevWr = 4'hF;
  logic [3:0]  prevWrF = 4'hF;
  logic [8:0]  prevDA = '0;
  logic [8:0]  fallDA = '0;
  int lowCnt = 0, stableCnt = 0;
  int strobes = 0, strobesInFrame = 0, lastFrameStrobes = 0, frames = 0;
  int frameStartCyc = 0, prevFrameStartCyc = 0;
  int strobesInFrameF = 0, framesF = 0, frameStartF = 0;
  logic [10:0] firstWord = '0;
  logic [10:0] lastWord = '0;
  logic [6:0]  dispLog[16];

  hpdl1414_scanner #(
    .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE), .HOLD_CYCLES(HOLD),
    .REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .o_read_enable(readEn), .o_read_address(readAddr), .i_read_data(rdata),
    .o_caret_strobe(caret), .o_disp_data(dispData), .o_disp_addr(dispAddr),
    .o_disp_wr_n(wrN)
  );

  hpdl1414_scanner #(
    .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE), .HOLD_CYCLES(HOLD),
    .REFRESH_DIV(RDIV_FAST), .BLINK_DIV(BDIV)
  ) dut_fast (
    .i_clk(clk), .i_rst_n(rst_fast_n), .i_enable(en_fast),
    .o_read_enable(readEnF), .o_read_address(readAddrF), .i_read_data(rdataF),
    .o_caret_strobe(caretF), .o_disp_data(dispDataF), .o_disp_addr(dispAddrF),
    .o_disp_wr_n(wrNF)
  );

  always #5 clk = ~clk;

  // Registered character memories: data valid the clock after the read request.
  always @(posedge clk) begin
    if (readEn) rdata <= mem[readAddr];
    if (readEnF) rdataF <= memF[readAddrF];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(posedge clk or negedge rst_fast_n) begin
    if (!rst_fast_n) cycF <= 0;
    else cycF <= cycF + 1;
  end

  function automatic logic [6:0] mapModel(input logic [7:0] b);
    logic [7:0] r;
    if (b inside {[8'h20:8'h5F]}) r = b;
    else if (b inside {[8'h61:8'h7A]}) r = b & 8'hDF;
    else r = 8'h20;
    return r[6:0];
  endfunction

  function automatic logic [10:0] expWord(input logic [3:0] k, input logic [7:0] b);
    logic [1:0] digit;
    digit = 2'd3 - k[1:0];
    return {k[3:2], digit, mapModel(b)};
  endfunction

  function automatic logic [1:0] chipOf(input logic [3:0] w);
    case (w)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic caretModel(input int c);
    return ((c / BDIV) % 2) == 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] bytes, input logic fast);
    for (int i = 0; i < 16; i++) begin
      if (fast) memF[i] = bytes[127 - 8*i -: 8];
      else mem[i] = bytes[127 - 8*i -: 8];
    end
  endtask

  task automatic waitStrobes(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (strobes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(strobes >= target), 32'd1);
  endtask

  task automatic waitFall(input string tag);
    int n;
    n = 0;
    while (wrN == 4'hF && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(wrN != 4'hF), 32'd1);
  endtask

  task automatic monitorLoop();
    logic [10:0] expected;
    logic [8:0]  da;
    forever begin
      @(negedge clk);
      da = {dispAddr, dispData};
      if (!rst_n) begin
        sbQueue.delete();
        restart = 1'b1;
        prevWr = 4'hF;
        lowCnt = 0;
        stableCnt = 0;
        frames = 0;
        strobesInFrame = 0;
      end else begin
        if (!en) restart = 1'b1;
        checkOutput("caret", 32'(caret), 32'(caretModel(cyc)));
        if (readEn) begin
          if (restart) begin
            expK = 4'd0;
            restart = 1'b0;
          end
          checkOutput("read_address", 32'(readAddr), 32'(expK));
          if (expK == 4'd0) begin
            prevFrameStartCyc = frameStartCyc;
            frameStartCyc = cyc;
            lastFrameStrobes = strobesInFrame;
            strobesInFrame = 0;
            frames++;
          end
          sbQueue.push_back(expWord(expK, mem[expK]));
          expK = expK + 4'd1;
        end
        stableCnt = (da == prevDA) ? stableCnt + 1 : 1;
        if (wrN != 4'hF && prevWr == 4'hF) begin
          checkOutput("wr_onehot", 32'($countones(~wrN)), 32'd1);
          checkOutput("setup_stable", 32'(stableCnt > SETUP), 32'd1);
          if (sbQueue.size() == 0) begin
            checkOutput("sb_underflow", 32'(sbQueue.size()), 32'd1);
          end else begin
            expected = sbQueue.pop_front();
            checkOutput("strobe_word", 32'({chipOf(wrN), da}), 32'(expected));
          end
          if (strobesInFrame == 0) firstWord = {chipOf(wrN), da};
          fallDA = da;
          lowCnt = 1;
        end else if (wrN != 4'hF) begin
          lowCnt++;
        end else if (prevWr != 4'hF) begin
          checkOutput("pulse_width", 32'(lowCnt), 32'(PULSE));
          checkOutput("hold_stable", 32'(da), 32'(fallDA));
          lastWord = {chipOf(prevWr), da};
          dispLog[strobesInFrame % 16] = da[6:0];
          strobesInFrame++;
          strobes++;
        end
        prevWr = wrN;
      end
      prevDA = da;

      if (rst_fast_n) begin
        checkOutput("fast_caret", 32'(caretF), 32'(caretModel(cycF)));
        if (readEnF) begin
          checkOutput("fast_read_address", 32'(readAddrF), 32'(expKF));
          if (expKF == 4'd0) begin
            if (framesF > 0) begin
              checkOutput("fast_frame_gap", 32'(cycF - frameStartF), 32'(FAST_FRAME));
              checkOutput("fast_frame_strobes", 32'(strobesInFrameF), 32'd16);
            end
            framesF++;
            frameStartF = cycF;
            strobesInFrameF = 0;
          end
          sbQueueF.push_back(expWord(expKF, memF[expKF]));
          expKF = expKF + 4'd1;
        end
        if (wrNF != 4'hF && prevWrF == 4'hF) begin
          if (sbQueueF.size() == 0) begin
            checkOutput("fast_sb_underflow", 32'(sbQueueF.size()), 32'd1);
          end else begin
            expected = sbQueueF.pop_front();
            checkOutput("fast_strobe_word", 32'({chipOf(wrNF), dispAddrF, dispDataF}), 32'(expected));
          end
          strobesInFrameF++;
        end
        prevWrF = wrNF;
      end
    end
  endtask

  initial begin
    int base;
    applyStimulus("HELLO WORLD    !", 1'b0);
    applyStimulus("back2back frame.", 1'b1);
    #1;
    rst_n = 1'b0;
    rst_fast_n = 1'b0;
    fork
      monitorLoop();
    join_none
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_wr_n", 32'(wrN), 32'hF);
    checkOutput("rst_disp_data", 32'(dispData), 32'h0);
    checkOutput("rst_disp_addr", 32'(dispAddr), 32'h0);
    checkOutput("rst_read_enable", 32'(readEn), 32'h0);
    checkOutput("rst_read_address", 32'(readAddr), 32'h0);
    checkOutput("rst_caret", 32'(caret), 32'h1);
    rst_n = 1'b1;
    rst_fast_n = 1'b1;

    $display("[TB] first frame: HELLO WORLD");
    waitStrobes(16, 300, "frame1_done");
    checkOutput("first_frame_start", 32'(frameStartCyc), 32'd1);
    checkOutput("frame1_first_write", 32'(firstWord), 32'({2'd0, 2'd3, 7'h48}));
    checkOutput("frame1_last_write", 32'(lastWord), 32'({2'd3, 2'd0, 7'h21}));
    base = 0;
    while (frames < 2 && base < 300) begin
      @(negedge clk);
      base++;
    end
    checkOutput("frame2_started", 32'(frames), 32'd2);
    checkOutput("frame_interval", 32'(frameStartCyc - prevFrameStartCyc), 32'(RDIV));
    checkOutput("frame1_strobe_count", 32'(lastFrameStrobes), 32'd16);

    $display("[TB] character map");
    waitStrobes(32, 300, "frame2_done");
    applyStimulus(128'h617A0A7F5F001F20607BFF80415A2A7E, 1'b0);
    waitStrobes(48, 400, "frame3_done");
    checkOutput("map_61", 32'(dispLog[0]), 32'h41);
    checkOutput("map_7A", 32'(dispLog[1]), 32'h5A);
    checkOutput("map_0A", 32'(dispLog[2]), 32'h20);
    checkOutput("map_7F", 32'(dispLog[3]), 32'h20);
    checkOutput("map_5F", 32'(dispLog[4]), 32'h5F);

    $display("[TB] enable dropped mid-strobe");
    waitStrobes(51, 400, "frame4_chars");
    waitFall("frame4_char3_fall");
    en = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("disabled_strobes", 32'(strobes), 32'd52);
    checkOutput("disabled_read_enable", 32'(readEn), 32'd0);
    checkOutput("disabled_wr_n", 32'(wrN), 32'hF);
    en = 1'b1;
    waitStrobes(53, 400, "resume_first_char");
    checkOutput("resume_frame_start", 32'(frameStartCyc), 32'(4 * RDIV + 1));
    checkOutput("resume_first_write", 32'(firstWord), 32'({2'd0, 2'd3, 7'h41}));

    $display("[TB] reset during strobe of char 6");
    waitStrobes(68, 400, "frame5_done");
    applyStimulus("HELLO WORLD    !", 1'b0);
    waitStrobes(74, 400, "frame6_chars");
    waitFall("char6_fall");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_wr_n", 32'(wrN), 32'hF);
    checkOutput("async_disp_data", 32'(dispData), 32'h0);
    checkOutput("async_disp_addr", 32'(dispAddr), 32'h0);
    checkOutput("async_read_enable", 32'(readEn), 32'h0);
    checkOutput("async_caret", 32'(caret), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = strobes;
    waitStrobes(base + 1, 100, "restart_first_char");
    checkOutput("restart_frame_start", 32'(frameStartCyc), 32'd1);
    checkOutput("restart_first_write", 32'(firstWord), 32'({2'd0, 2'd3, 7'h48}));
    waitStrobes(base + 16, 300, "restart_frame_done");
    checkOutput("restart_last_write", 32'(lastWord), 32'({2'd3, 2'd0, 7'h21}));
    checkOutput("fast_frames_seen", 32'(framesF > 5), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
